time_code_gen: RTL

- Real-time-of-day source for the lighting path. It counts seconds, minutes and hours from a one-second strobe.
- It maps the current hour to the 4-bit time code consumed by the active-lamp calculator.
- The time code is one-hot, or zero:
  - 0000 = night
  - 0001 = morning
  - 0010 = afternoon
  - 0100 = evening
  - 1000 = late
- It also accepts a time-set handshake from the house controller and flags every time-code change.

---
 rtl/time_code_gen_if.sv | 18 +
 rtl/time_code_gen.sv | 138 +++++++++++++
 2 files changed

// File: rtl/time_code_gen_if.sv
// Time-set handshake between the house controller (master) and time_code_gen (slave).
interface time_code_gen_if;
    logic       set_valid;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic       set_ready;
    logic       set_err;

    modport master (
        output set_valid, set_hour, set_min,
        input  set_ready, set_err
    );

    modport slave (
        input  set_valid, set_hour, set_min,
        output set_ready, set_err
    );
endinterface

// File: rtl/time_code_gen.sv
// Time-of-day counter (sec/min/hour) with one-hot time-code decode and time-set handshake.
// Optional TCODE_OVERRIDE_EN adds ovr_en/ovr_code to force the time code externally.
module time_code_gen #(
    parameter int unsigned SEC_PER_MIN = 60,
    parameter int unsigned MORNING_H   = 6,
    parameter int unsigned NOON_H      = 12,
    parameter int unsigned EVENING_H   = 17,
    parameter int unsigned LATE_H      = 21
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sec_tick,
    input  logic                  run_en,
    time_code_gen_if.slave        set_if,
`ifdef TCODE_OVERRIDE_EN
    input  logic                  ovr_en,
    input  logic [3:0]            ovr_code,
`endif
    output logic [4:0]            hour,
    output logic [5:0]            minute,
    output logic [3:0]            tcode,
    output logic                  tcode_chg
);

    localparam int unsigned SEC_W = ($clog2(SEC_PER_MIN) < 1) ? 1 : $clog2(SEC_PER_MIN);
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_PER_MIN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SET  = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [4:0]       r_hour, w_hour_nxt;
    logic [5:0]       r_min, w_min_nxt;
    logic [SEC_W-1:0] r_sec, w_sec_nxt;
    logic [4:0]       r_cap_hour;
    logic [5:0]       r_cap_min;
    logic [3:0]       r_tcode, w_tcode_nxt;
    logic             r_tcode_chg;
    logic             w_set_ready;
    logic             w_accept;
    logic             w_set_ok;

    function automatic logic [3:0] f_decode(input logic [4:0] h);
        if (32'(h) >= LATE_H)         return 4'b1000;
        else if (32'(h) >= EVENING_H) return 4'b0100;
        else if (32'(h) >= NOON_H)    return 4'b0010;
        else if (32'(h) >= MORNING_H) return 4'b0001;
        else                          return 4'b0000;
    endfunction

    assign w_set_ready = (r_state != SET) && !rst;
    assign w_accept    = set_if.set_valid && w_set_ready;
    assign w_set_ok    = (r_cap_hour <= 5'd23) && (r_cap_min <= 6'd59);

    always_comb begin
        w_state_nxt = r_state;
        w_hour_nxt  = r_hour;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;
        unique case (r_state)
            IDLE: begin
                if (set_if.set_valid)  w_state_nxt = SET;
                else if (run_en)       w_state_nxt = RUN;
            end
            RUN: begin
                if (set_if.set_valid) begin
                    w_state_nxt = SET;
                end else if (!run_en) begin
                    w_state_nxt = IDLE;
                end else if (sec_tick) begin
                    // Full sec->min->hour carry resolves within this one tick.
                    if (r_sec == SEC_LAST) begin
                        w_sec_nxt = '0;
                        if (r_min == 6'd59) begin
                            w_min_nxt  = '0;
                            w_hour_nxt = (r_hour == 5'd23) ? '0 : r_hour + 5'd1;
                        end else begin
                            w_min_nxt = r_min + 6'd1;
                        end
                    end else begin
                        w_sec_nxt = r_sec + SEC_W'(1);
                    end
                end
            end
            SET: begin
                if (w_set_ok) begin
                    w_hour_nxt = r_cap_hour;
                    w_min_nxt  = r_cap_min;
                    w_sec_nxt  = '0;
                end
                w_state_nxt = run_en ? RUN : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_tcode_nxt = f_decode(w_hour_nxt);
`ifdef TCODE_OVERRIDE_EN
        if (ovr_en) w_tcode_nxt = $onehot0(ovr_code) ? ovr_code : r_tcode;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_hour      <= '0;
            r_min       <= '0;
            r_sec       <= '0;
            r_cap_hour  <= '0;
            r_cap_min   <= '0;
            r_tcode     <= '0;
            r_tcode_chg <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hour      <= w_hour_nxt;
            r_min       <= w_min_nxt;
            r_sec       <= w_sec_nxt;
            r_tcode     <= w_tcode_nxt;
            r_tcode_chg <= (w_tcode_nxt != r_tcode);
            if (w_accept) begin
                r_cap_hour <= set_if.set_hour;
                r_cap_min  <= set_if.set_min;
            end
        end
    end

    assign set_if.set_ready = w_set_ready;
    assign set_if.set_err   = (r_state == SET) && !w_set_ok && !rst;
    assign hour             = r_hour;
    assign minute           = r_min;
    assign tcode            = r_tcode;
    assign tcode_chg        = r_tcode_chg;

endmodule
